// File: rtl/hex2dec_arbiter.sv
// ---------------------------------------------------------------------------
// hex2dec_arbiter
//
// Shares one external pipelined hex-to-decimal converter between two
// requesters (A and B). Each requester owns a DEPTH-entry result FIFO.
// Credit counters stop a requester from issuing more requests than its FIFO
// can hold, which means a result arriving from the converter always has room.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   a_valid/a_ready/a_data   requester A operand handshake (7-bit binary)
//   b_valid/b_ready/b_data   requester B operand handshake (7-bit binary)
//   conv_h                   registered operand to the converter
//   conv_dh, conv_dl         converter tens/units, valid LAT cycles after
//                            conv_h is sampled
//   ra_valid/ra_ready        A result handshake
//   ra_dh, ra_dl, ra_ovr     A result tens, units, operand>99 flag
//   rb_valid/rb_ready        B result handshake
//   rb_dh, rb_dl, rb_ovr     B result tens, units, operand>99 flag
//   busy                     conversion in flight or any FIFO non-empty
// ---------------------------------------------------------------------------

// Checker: a result FIFO must never be written while full.
module hex2dec_arbiter_chk (
   input logic       clk,
   input logic       rst,
   input logic [1:0] fifo_wr,
   input logic [1:0] fifo_full
);
   a_no_write_when_full: assert property (
      @(posedge clk) disable iff (rst) ((fifo_wr & fifo_full) == 2'b00));
endmodule

// One requester's credit counter and first-word-fall-through result FIFO.
// Entry layout: {ovr, dh[3:0], dl[3:0]}.
module hex2dec_arbiter_side #(
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       grant,
   input  logic       wr_en,
   input  logic [8:0] wr_data,
   input  logic       rd_ready,
   output logic       rd_valid,
   output logic [8:0] rd_data,
   output logic       has_credit,
   output logic       full
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW:0] ONE_W   = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] ZERO_W  = {(AW + 1){1'b0}};

   logic [AW:0]            credit_q, credit_d;
   logic [AW:0]            wr_ptr_q, wr_ptr_d;
   logic [AW:0]            rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0][8:0]  mem_q, mem_d;
   logic [AW:0]            count;
   logic                   empty;
   logic                   pop;

   // FIFO status and head-of-queue presentation (zero when empty).
   always_comb begin
      count      = wr_ptr_q - rd_ptr_q;
      empty      = (count == ZERO_W);
      full       = (count == DEPTH_W);
      rd_valid   = ~empty;
      pop        = ~empty & rd_ready;
      has_credit = (credit_q != ZERO_W);
      if (!empty) begin
         rd_data = mem_q[rd_ptr_q[AW-1:0]];
      end else begin
         rd_data = 9'd0;
      end
   end

   // Next-state for FIFO storage, pointers and credit.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      credit_d = credit_q;
      if (wr_en) begin
         mem_d[wr_ptr_q[AW-1:0]] = wr_data;
         wr_ptr_d                = wr_ptr_q + ONE_W;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + ONE_W;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      // A grant reserves a slot; a pop releases one; both cancel out.
      case ({grant, pop})
         2'b10:   credit_d = credit_q - ONE_W;
         2'b01:   credit_d = credit_q + ONE_W;
         default: credit_d = credit_q;
      endcase
   end

   // State registers; credits restart full.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '0;
         wr_ptr_q <= ZERO_W;
         rd_ptr_q <= ZERO_W;
         credit_q <= DEPTH_W;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         credit_q <= credit_d;
      end
   end
endmodule

module hex2dec_arbiter #(
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       a_valid,
   output logic       a_ready,
   input  logic [6:0] a_data,
   input  logic       b_valid,
   output logic       b_ready,
   input  logic [6:0] b_data,
   output logic [6:0] conv_h,
   input  logic [3:0] conv_dh,
   input  logic [3:0] conv_dl,
   output logic       ra_valid,
   input  logic       ra_ready,
   output logic [3:0] ra_dh,
   output logic [3:0] ra_dl,
   output logic       ra_ovr,
   output logic       rb_valid,
   input  logic       rb_ready,
   output logic [3:0] rb_dh,
   output logic [3:0] rb_dl,
   output logic       rb_ovr,
   output logic       busy
);
   // rr_ptr: 0 = A has priority on a tie, 1 = B.
   logic           rr_ptr_q, rr_ptr_d;
   logic [6:0]     conv_h_q, conv_h_d;
   logic [LAT:0]   tag_valid_q, tag_valid_d;
   logic [LAT:0]   tag_side_q, tag_side_d;
   logic [LAT:0]   tag_ovr_q, tag_ovr_d;

   logic           a_credit, b_credit;
   logic           a_elig, b_elig;
   logic           a_grant, b_grant;
   logic [6:0]     grant_data;
   logic           a_wr, b_wr;
   logic           a_full, b_full;
   logic [8:0]     wr_data;
   logic [8:0]     ra_data, rb_data;

   // Arbitration. Requests are masked during reset so ready reads low.
   always_comb begin
      a_elig  = a_valid & a_credit & ~rst;
      b_elig  = b_valid & b_credit & ~rst;
      a_grant = a_elig & (~b_elig | ~rr_ptr_q);
      b_grant = b_elig & (~a_elig | rr_ptr_q);
      a_ready = a_credit & ~rst & (~b_elig | ~rr_ptr_q);
      b_ready = b_credit & ~rst & (~a_elig | rr_ptr_q);
      if (b_grant) begin
         grant_data = b_data;
      end else begin
         grant_data = a_data;
      end
   end

   // Next-state for priority pointer, converter operand and tag pipeline.
   always_comb begin
      if (a_grant) begin
         rr_ptr_d = 1'b1;
         conv_h_d = a_data;
      end else if (b_grant) begin
         rr_ptr_d = 1'b0;
         conv_h_d = b_data;
      end else begin
         rr_ptr_d = rr_ptr_q;
         conv_h_d = conv_h_q;
      end
      // Stage 0 is loaded together with conv_h; stage LAT lines up with
      // the converter result for that operand.
      tag_valid_d = {tag_valid_q[LAT-1:0], a_grant | b_grant};
      tag_side_d  = {tag_side_q[LAT-1:0], b_grant};
      tag_ovr_d   = {tag_ovr_q[LAT-1:0], (grant_data > 7'd99)};
   end

   // Arbiter and tag pipeline registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q    <= 1'b0;
         conv_h_q    <= 7'd0;
         tag_valid_q <= '0;
         tag_side_q  <= '0;
         tag_ovr_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         conv_h_q    <= conv_h_d;
         tag_valid_q <= tag_valid_d;
         tag_side_q  <= tag_side_d;
         tag_ovr_q   <= tag_ovr_d;
      end
   end

   assign conv_h  = conv_h_q;
   assign a_wr    = tag_valid_q[LAT] & ~tag_side_q[LAT];
   assign b_wr    = tag_valid_q[LAT] & tag_side_q[LAT];
   assign wr_data = {tag_ovr_q[LAT], conv_dh, conv_dl};

   hex2dec_arbiter_side #(.DEPTH(DEPTH)) u_side_a (
      .clk        (clk),
      .rst        (rst),
      .grant      (a_grant),
      .wr_en      (a_wr),
      .wr_data    (wr_data),
      .rd_ready   (ra_ready),
      .rd_valid   (ra_valid),
      .rd_data    (ra_data),
      .has_credit (a_credit),
      .full       (a_full)
   );

   hex2dec_arbiter_side #(.DEPTH(DEPTH)) u_side_b (
      .clk        (clk),
      .rst        (rst),
      .grant      (b_grant),
      .wr_en      (b_wr),
      .wr_data    (wr_data),
      .rd_ready   (rb_ready),
      .rd_valid   (rb_valid),
      .rd_data    (rb_data),
      .has_credit (b_credit),
      .full       (b_full)
   );

   assign ra_ovr = ra_data[8];
   assign ra_dh  = ra_data[7:4];
   assign ra_dl  = ra_data[3:0];
   assign rb_ovr = rb_data[8];
   assign rb_dh  = rb_data[7:4];
   assign rb_dl  = rb_data[3:0];
   assign busy   = (|tag_valid_q) | ra_valid | rb_valid;

   hex2dec_arbiter_chk u_chk (
      .clk       (clk),
      .rst       (rst),
      .fifo_wr   ({b_wr, a_wr}),
      .fifo_full ({b_full, a_full})
   );
endmodule

// File: tb/tb_hex2dec_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hex2dec_arbiter
// Directed bench for hex2dec_arbiter. A behavioural LAT-stage converter
// drives conv_dh/conv_dl. Accepted requests push their expected decimal
// result into a per-side queue; every consumed result is popped and compared.
// ---------------------------------------------------------------------------
module tb_hex2dec_arbiter;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       a_valid = 1'b0, b_valid = 1'b0;
   logic       a_ready, b_ready;
   logic [6:0] a_data = 7'd0, b_data = 7'd0;
   logic [6:0] conv_h;
   logic [3:0] conv_dh, conv_dl;
   logic       ra_valid, rb_valid;
   logic       ra_ready = 1'b0, rb_ready = 1'b0;
   logic [3:0] ra_dh, ra_dl, rb_dh, rb_dl;
   logic       ra_ovr, rb_ovr;
   logic       busy;

   int n_vec = 0;
   int n_mis = 0;
   logic [8:0] exp_a[$];
   logic [8:0] exp_b[$];
   logic [7:0] cpipe [LAT];

   hex2dec_arbiter #(.LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
      .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
      .conv_h(conv_h), .conv_dh(conv_dh), .conv_dl(conv_dl),
      .ra_valid(ra_valid), .ra_ready(ra_ready),
      .ra_dh(ra_dh), .ra_dl(ra_dl), .ra_ovr(ra_ovr),
      .rb_valid(rb_valid), .rb_ready(rb_ready),
      .rb_dh(rb_dh), .rb_dl(rb_dl), .rb_ovr(rb_ovr),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Expected result layout {dh, dl, ovr}.
   function automatic logic [8:0] model(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10), (v > 7'd99)};
   endfunction

   // Converter model: LAT register stages from conv_h.
   always @(posedge clk) begin
      cpipe[0] <= {4'(conv_h / 7'd10), 4'(conv_h % 7'd10)};
      for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
   end
   assign conv_dh = cpipe[LAT-1][7:4];
   assign conv_dl = cpipe[LAT-1][3:0];

   task automatic check(input string tag, input int obs, input int expv);
      n_vec++;
      assert (obs === expv) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on consume.
   always @(negedge clk) begin
      logic [8:0] e;
      if (!rst) begin
         if (a_valid && a_ready) exp_a.push_back(model(a_data));
         if (b_valid && b_ready) exp_b.push_back(model(b_data));
         if (ra_valid && ra_ready) begin
            n_vec++;
            e = (exp_a.size() != 0) ? exp_a.pop_front() : 9'h1ff;
            assert ({ra_dh, ra_dl, ra_ovr} === e) else begin
               n_mis++;
               $error("FAIL ra_result: observed %h expected %h", {ra_dh, ra_dl, ra_ovr}, e);
            end
         end
         if (rb_valid && rb_ready) begin
            n_vec++;
            e = (exp_b.size() != 0) ? exp_b.pop_front() : 9'h1ff;
            assert ({rb_dh, rb_dl, rb_ovr} === e) else begin
               n_mis++;
               $error("FAIL rb_result: observed %h expected %h", {rb_dh, rb_dl, rb_ovr}, e);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      ra_ready = 1'b1;
      rb_ready = 1'b1;
      a_valid  = 1'b0;
      b_valid  = 1'b0;
      for (int k = 0; k < 200 && (busy || exp_a.size() != 0 || exp_b.size() != 0); k++) step();
      check("drain_busy", int'(busy), 0);
      check("drain_queues", exp_a.size() + exp_b.size(), 0);
   endtask

   initial begin
      int na, nb, acc_a, acc_b;
      logic ga, gb;
      logic [6:0] vals [4];
      vals = '{7'd0, 7'd99, 7'd100, 7'd127};

      // Reset state, with requests pending so ready gating is exercised.
      #1 rst = 1'b1;
      a_valid = 1'b1;
      b_valid = 1'b1;
      step();
      step();
      check("rst_a_ready", int'(a_ready), 0);
      check("rst_b_ready", int'(b_ready), 0);
      check("rst_rx_valid", int'({ra_valid, rb_valid}), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_conv_h", int'(conv_h), 0);
      check("rst_results", int'({ra_dh, ra_dl, ra_ovr, rb_dh, rb_dl, rb_ovr}), 0);
      a_valid = 1'b0;
      b_valid = 1'b0;
      rst = 1'b0;
      #1 check("post_rst_a_ready", int'(a_ready), 1);

      // Both sides streaming: grants alternate starting with A.
      ra_ready = 1'b1;
      rb_ready = 1'b1;
      a_valid  = 1'b1;
      b_valid  = 1'b1;
      na = 0;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         a_data = 7'(10 + na);
         b_data = 7'(20 + nb);
         @(negedge clk);
         ga = a_ready;
         gb = b_ready;
         check("rr_onehot", int'(ga) + int'(gb), 1);
         check("rr_side", int'(gb), i % 2);
         step();
         if (ga) na++;
         if (gb) nb++;
      end
      drain();
      check("rr_count_a", na, 4);
      check("rr_count_b", nb, 4);

      // Single request 45: conv_h next cycle, result five cycles later.
      a_data  = 7'd45;
      a_valid = 1'b1;
      @(negedge clk);
      check("lat_a_ready", int'(a_ready), 1);
      step();
      a_valid = 1'b0;
      check("lat_conv_h", int'(conv_h), 45);
      check("lat_busy", int'(busy), 1);
      check("lat_early_n1", int'(ra_valid), 0);
      for (int k = 2; k < 5; k++) begin
         step();
         check("lat_early", int'(ra_valid), 0);
      end
      step();
      check("lat_valid", int'(ra_valid), 1);
      check("lat_value", int'({ra_dh, ra_dl, ra_ovr}), int'({4'd4, 4'd5, 1'b0}));
      step();
      check("lat_popped", int'(ra_valid), 0);

      // Boundary operands 0, 99, 100, 127.
      for (int i = 0; i < 4; i++) begin
         a_data  = vals[i];
         a_valid = 1'b1;
         @(negedge clk);
         check("bnd_a_ready", int'(a_ready), 1);
         step();
      end
      drain();

      // A backpressured: four accepts then stall; B still served.
      ra_ready = 1'b0;
      rb_ready = 1'b1;
      a_valid  = 1'b1;
      b_valid  = 1'b1;
      acc_a = 0;
      acc_b = 0;
      for (int i = 0; i < 12; i++) begin
         a_data = 7'(30 + acc_a);
         b_data = 7'(60 + acc_b);
         @(negedge clk);
         ga = a_ready;
         gb = b_ready;
         step();
         if (ga) acc_a++;
         if (gb) acc_b++;
      end
      check("bp_a_accepts", acc_a, 4);
      check("bp_a_ready_low", int'(a_ready), 0);
      check("bp_b_served", int'(acc_b >= 4), 1);
      b_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
      check("bp_fifo_full_valid", int'(ra_valid), 1);
      // One pop releases exactly one further acceptance.
      ra_ready = 1'b1;
      step();
      ra_ready = 1'b0;
      acc_a = 0;
      for (int i = 0; i < 8; i++) begin
         a_data = 7'(50 + acc_a);
         @(negedge clk);
         ga = a_ready;
         step();
         if (ga) acc_a++;
      end
      check("bp_one_more", acc_a, 1);
      // Pop at zero credit, then grant with pop, then grant alone.
      a_data   = 7'd70;
      ra_ready = 1'b1;
      @(negedge clk);
      check("cr_zero_ready", int'(a_ready), 0);
      step();
      a_data = 7'd71;
      @(negedge clk);
      check("cr_one_ready", int'(a_ready), 1);
      step();
      a_data   = 7'd72;
      ra_ready = 1'b0;
      @(negedge clk);
      check("cr_grant_pop_ready", int'(a_ready), 1);
      step();
      @(negedge clk);
      check("cr_exhausted_ready", int'(a_ready), 0);
      step();
      drain();

      // Reset with two requests in flight: their results are discarded.
      a_valid = 1'b1;
      a_data  = 7'd77;
      step();
      a_data = 7'd88;
      step();
      a_valid = 1'b0;
      check("mid_busy", int'(busy), 1);
      rst = 1'b1;
      #1;
      exp_a.delete();
      exp_b.delete();
      check("mid_rst_ready", int'({a_ready, b_ready}), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_conv_h", int'(conv_h), 0);
      step();
      step();
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("mid_post_idle", int'({ra_valid, rb_valid, busy}), 0);
      end
      ra_ready = 1'b0;
      rb_ready = 1'b0;
      a_valid  = 1'b1;
      b_valid  = 1'b1;
      acc_a = 0;
      acc_b = 0;
      for (int i = 0; i < 12; i++) begin
         a_data = 7'(100 + acc_a);
         b_data = 7'(5 + acc_b);
         @(negedge clk);
         ga = a_ready;
         gb = b_ready;
         step();
         if (ga) acc_a++;
         if (gb) acc_b++;
      end
      check("mid_accepts_a", acc_a, 4);
      check("mid_accepts_b", acc_b, 4);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end
endmodule
